// File: rtl/game_pkg.sv
// Shared types and default timing constants for the basketball game control logic.
package game_pkg;

    typedef enum logic [2:0] {
        GS_ARMED     = 3'd0,
        GS_QUAL_LOW  = 3'd1,
        GS_BLOCKED   = 3'd2,
        GS_QUAL_HIGH = 3'd3,
        GS_HOLDOFF   = 3'd4
    } gs_state_t;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEBOUNCE_1MS = 50_000;
    localparam int HOLDOFF_1S   = 50_000_000;
    localparam int GOAL_W       = 6;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for asynchronous inputs; resets to 1 (idle level of active-low inputs).
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic Clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) chain <= '1;
        else      chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/goal_sensor_filter.sv
// Break-beam hoop sensor conditioner: synchronise, debounce both edges, one pulse per ball,
// post-release hold-off, enable gating and a saturating goal tally.
//
// state        | meaning
// GS_ARMED     | beam clear, waiting for a break
// GS_QUAL_LOW  | break seen, counting stable-low samples
// GS_BLOCKED   | break accepted, waiting for the beam to clear
// GS_QUAL_HIGH | clear seen, counting stable-high samples
// GS_HOLDOFF   | release accepted, sensor ignored until the lockout expires
module goal_sensor_filter
    import game_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int HOLDOFF_CYCLES  = HOLDOFF_1S,
    parameter int COUNT_W         = GOAL_W
) (
    input  logic               CLOCK_50,
    input  logic               Clr,
    input  logic               sensor_n,
    input  logic               enable,
    input  logic               new_game,
    output logic               goal_pulse,
    output logic               reject_pulse,
    output logic               beam_blocked,
    output logic               holdoff_active,
    output logic [COUNT_W-1:0] goal_count
);

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    gs_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             goal_accept;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .Clk (CLOCK_50),
        .Clr (Clr),
        .d   (sensor_n),
        .q   (s)
    );

    always_ff @(posedge CLOCK_50 or negedge Clr) begin
        if (!Clr) begin
            state          <= GS_ARMED;
            cnt            <= '0;
            goal_pulse     <= 1'b0;
            reject_pulse   <= 1'b0;
            beam_blocked   <= 1'b0;
            holdoff_active <= 1'b0;
        end else begin
            goal_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
            case (state)
                GS_ARMED: begin
                    if (!s) begin
                        state <= GS_QUAL_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                GS_QUAL_LOW: begin
                    if (s) begin
                        state <= GS_ARMED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state        <= GS_BLOCKED;
                        cnt          <= '0;
                        beam_blocked <= 1'b1;
                        goal_pulse   <= enable;
                        reject_pulse <= !enable;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GS_BLOCKED: begin
                    if (s) begin
                        state <= GS_QUAL_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                GS_QUAL_HIGH: begin
                    if (!s) begin
                        state <= GS_BLOCKED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state          <= GS_HOLDOFF;
                        cnt            <= '0;
                        beam_blocked   <= 1'b0;
                        holdoff_active <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GS_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        cnt            <= '0;
                        holdoff_active <= 1'b0;
                        // A ball still in the hoop at expiry must clear before it can score again
                        if (!s) begin
                            state        <= GS_BLOCKED;
                            beam_blocked <= 1'b1;
                        end else begin
                            state <= GS_ARMED;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state          <= GS_ARMED;
                    cnt            <= '0;
                    beam_blocked   <= 1'b0;
                    holdoff_active <= 1'b0;
                end
            endcase
        end
    end

    // Tally moves on the same edge that raises goal_pulse
    assign goal_accept = (state == GS_QUAL_LOW) && !s && (cnt == DEB_LAST) && enable;

    always_ff @(posedge CLOCK_50 or negedge Clr) begin
        if (!Clr) begin
            goal_count <= '0;
        end else if (new_game) begin
            goal_count <= '0;
        end else if (goal_accept && (goal_count != COUNT_MAX)) begin
            goal_count <= goal_count + 1'b1;
        end
    end

endmodule
